// File: rtl/lsu_pkg.sv
// lsu_pkg: shared LSU op, width, FSM state and exception cause definitions
package lsu_pkg;
  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_STORE} mem_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT_DATA, S_DONE} lsu_state_e;
  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
endpackage

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: flags halfword/word accesses not aligned to their natural size
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] width,
  output logic       misaligned
);
  assign misaligned = (width == W_HALF && addr[0]) || (width == W_WORD && addr != 2'b00);
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM pipeline stage issuing one load/store to the data cache and handing the result to WB
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [2:0]  ex_width,
  input  logic        ex_sign,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dc_ren,
  output logic        dc_wen,
  output logic        dc_pipeline_en,
  output logic        dc_rsign,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [2:0]  dc_rwidth,
  output logic [2:0]  dc_wwidth,
  input  logic [31:0] dc_rdata,
  input  logic        dc_valid,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exc,
  output logic [3:0]  wb_cause,
  output logic [31:0] wb_badaddr
);
  lsu_state_e  state;
  mem_op_e     op;
  logic [31:0] addr, wdata;
  logic [2:0]  width;
  logic        sign, mis, acc, is_ld, is_st, is_mem, fault;
  lsu_align_chk u_align (.addr(ex_addr[1:0]), .width(ex_width), .misaligned(mis));
  assign is_ld  = mem_op_e'(ex_op) == OP_LOAD;
  assign is_st  = mem_op_e'(ex_op) == OP_STORE;
  assign is_mem = is_ld || is_st;
  assign fault  = is_mem && mis;
  assign ex_ready = state == S_IDLE || (state == S_DONE && wb_ready);
  assign acc = ex_valid && ex_ready;
  assign dc_pipeline_en = state == S_ACCESS;
  assign dc_ren    = dc_pipeline_en && op == OP_LOAD;
  assign dc_wen    = dc_pipeline_en && op == OP_STORE;
  assign dc_addr   = addr;
  assign dc_wdata  = wdata;
  assign dc_rwidth = width;
  assign dc_wwidth = width;
  assign dc_rsign  = sign;
  // Exception and pass-through results are settled at accept; only load data arrives later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op         <= OP_NONE;
      addr       <= '0;
      wdata      <= '0;
      width      <= '0;
      sign       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_exc     <= 1'b0;
      wb_cause   <= '0;
      wb_badaddr <= '0;
    end else if (acc) begin
      op         <= mem_op_e'(ex_op);
      addr       <= ex_addr;
      wdata      <= ex_wdata;
      width      <= ex_width;
      sign       <= ex_sign;
      wb_rd      <= ex_rd;
      wb_exc     <= fault;
      wb_cause   <= fault ? (is_ld ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN) : 4'd0;
      wb_badaddr <= fault ? ex_addr : 32'd0;
      wb_data    <= is_mem ? 32'd0 : ex_wdata;
      state      <= is_mem && !mis ? S_ACCESS : S_DONE;
      wb_valid   <= !(is_mem && !mis);
    end else begin
      case (state)
        S_ACCESS: if (dc_valid) begin
          state    <= op == OP_LOAD ? S_WAIT_DATA : S_DONE;
          wb_valid <= op != OP_LOAD;
        end
        S_WAIT_DATA: begin
          wb_data  <= dc_rdata;
          state    <= S_DONE;
          wb_valid <= 1'b1;
        end
        S_DONE: if (wb_ready) begin
          state    <= S_IDLE;
          wb_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_ready;
  logic [1:0]  ex_op = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic [2:0]  ex_width = 0;
  logic        ex_sign = 0;
  logic [4:0]  ex_rd = 0;
  logic        dc_ren, dc_wen, dc_pipeline_en, dc_rsign;
  logic [31:0] dc_addr, dc_wdata, dc_rdata = 0;
  logic [2:0]  dc_rwidth, dc_wwidth;
  logic        dc_valid = 0;
  logic        wb_valid, wb_ready = 0, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_badaddr;
  logic [3:0]  wb_cause;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_width(ex_width), .ex_sign(ex_sign), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dc_ren(dc_ren), .dc_wen(dc_wen), .dc_pipeline_en(dc_pipeline_en), .dc_rsign(dc_rsign),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_rwidth(dc_rwidth), .dc_wwidth(dc_wwidth),
    .dc_rdata(dc_rdata), .dc_valid(dc_valid), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc), .wb_cause(wb_cause), .wb_badaddr(wb_badaddr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] width,
                       input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid = 1; ex_op = op; ex_addr = addr; ex_width = width; ex_wdata = wdata; ex_rd = rd;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] width,
                       input logic [31:0] wdata, input logic [4:0] rd);
    drive(op, addr, width, wdata, rd);
    step();
    ex_valid = 0;
  endtask
  task automatic drain();
    wb_ready = 1;
    step();
    wb_ready = 0;
    check("drain_idle", {30'd0, wb_valid, ex_ready}, 32'd1);
  endtask
  initial begin
    #1;
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_outs", {28'd0, wb_valid, dc_ren, dc_wen, dc_pipeline_en}, 32'd0);
    check("rst_wb", wb_data | wb_badaddr | dc_addr, 32'd0);
    @(negedge clk) rst_n = 1;
    step();
    // aligned word load, cache hit
    dc_valid = 1; dc_rdata = 32'hDEADBEEF;
    issue(2'd1, 32'h100, 3'd4, 32'h0, 5'd3);
    check("ld_access", {28'd0, dc_ren, dc_wen, dc_pipeline_en, ex_ready}, 32'b1010);
    check("ld_addr", dc_addr, 32'h100);
    check("ld_rwidth", {29'd0, dc_rwidth}, 32'd4);
    check("ld_noval_e1", {31'd0, wb_valid}, 32'd0);
    step();
    check("ld_wait", {29'd0, wb_valid, dc_ren, dc_pipeline_en}, 32'd0);
    step();
    check("ld_valid_e2", {31'd0, wb_valid}, 32'd1);
    check("ld_data", wb_data, 32'hDEADBEEF);
    check("ld_exc_rd", {26'd0, wb_exc, wb_rd}, 32'd3);
    drain();
    // store halfword with a 3-cycle miss stall
    dc_valid = 0;
    issue(2'd2, 32'h204, 3'd2, 32'h1234, 5'd5);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dc_valid = 1;
      check("st_wen", {29'd0, dc_wen, dc_ren, wb_valid}, 32'b100);
      check("st_addr", dc_addr, 32'h204);
      check("st_wwidth", {29'd0, dc_wwidth}, 32'd2);
      check("st_wdata", dc_wdata, 32'h1234);
      step();
    end
    check("st_done", {30'd0, wb_valid, dc_wen}, 32'b10);
    check("st_data", wb_data, 32'd0);
    drain();
    // misaligned load
    dc_valid = 1;
    drive(2'd1, 32'h103, 3'd4, 32'h0, 5'd8);
    #1 check("mis_ld_noren_pre", {31'd0, dc_ren}, 32'd0);
    step();
    ex_valid = 0;
    check("mis_ld_valid", {29'd0, wb_valid, wb_exc, dc_ren}, 32'b110);
    check("mis_ld_cause", {28'd0, wb_cause}, 32'd4);
    check("mis_ld_badaddr", wb_badaddr, 32'h103);
    drain();
    // misaligned store
    issue(2'd2, 32'h201, 3'd2, 32'hFFFF, 5'd9);
    check("mis_st_valid", {29'd0, wb_valid, wb_exc, dc_wen}, 32'b110);
    check("mis_st_cause", {28'd0, wb_cause}, 32'd6);
    check("mis_st_badaddr", wb_badaddr, 32'h201);
    drain();
    // byte at odd address is aligned
    issue(2'd1, 32'h207, 3'd1, 32'h0, 5'd1);
    check("byte_odd_access", {30'd0, dc_ren, wb_exc}, 32'b10);
    step();
    step();
    check("byte_odd_done", {31'd0, wb_valid}, 32'd1);
    drain();
    // NONE held in DONE under backpressure, then back-to-back accept
    issue(2'd0, 32'h0, 3'd4, 32'hA5A5, 5'd7);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {wb_valid, ex_ready, wb_exc, wb_rd, wb_data[23:0]}, {3'b100, 5'd7, 24'hA5A5});
      step();
    end
    wb_ready = 1;
    drive(2'd0, 32'h0, 3'd4, 32'h77, 5'd9);
    #1 check("b2b_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 0; wb_ready = 0;
    check("b2b_data", wb_data, 32'h77);
    check("b2b_rd_valid", {26'd0, wb_valid, wb_rd}, {26'd0, 1'b1, 5'd9});
    drain();
    // async reset in the middle of a stalled store
    dc_valid = 0;
    issue(2'd2, 32'h300, 3'd4, 32'hCAFE, 5'd4);
    check("rst_pre_wen", {31'd0, dc_wen}, 32'd1);
    #2 rst_n = 0;
    #1 check("rst_async_outs", {28'd0, dc_wen, dc_pipeline_en, wb_valid, ex_ready}, 32'd1);
    check("rst_async_addr", dc_addr | dc_wdata, 32'd0);
    @(negedge clk) rst_n = 1;
    step();
    issue(2'd0, 32'h0, 3'd4, 32'h55, 5'd2);
    check("post_rst_none", wb_data, 32'h55);
    check("post_rst_valid", {30'd0, wb_valid, wb_exc}, 32'b10);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
